// File: rtl/assoc_cache_pkg.sv
// Shared types and width-derivation helpers for the set-associative cache controller.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL_REQ  = 3'd3,
        ST_FILL_WAIT = 3'd4
    } cache_state_e;

    function automatic int calc_offset_w(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int calc_index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int block_bytes, input int sets);
        return addr_w - $clog2(block_bytes) - $clog2(sets);
    endfunction

    function automatic int calc_byte_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int calc_word_sel_w(input int block_bytes, input int data_w);
        return calc_offset_w(block_bytes) - calc_byte_w(data_w);
    endfunction

    function automatic int calc_line_w(input int block_bytes);
        return block_bytes * 8;
    endfunction

    // Saturating event counter step
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/lru_age_set.sv
// True-age LRU state for one cache set: ages form a permutation of 0..WAYS-1, age WAYS-1 is the oldest.
module lru_age_set #(
    parameter int WAYS = 4,
    localparam int AGE_W = $clog2(WAYS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_touch,
    input  logic [AGE_W-1:0] i_way,
    output logic [AGE_W-1:0] o_oldest
);

    logic [AGE_W-1:0] r_age [WAYS];

    // Touched way becomes youngest; every younger way ages by one
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                r_age[w] <= AGE_W'(w);
            end
        end else if (i_touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == i_way) begin
                    r_age[w] <= {AGE_W{1'b0}};
                end else if (r_age[w] < r_age[i_way]) begin
                    r_age[w] <= r_age[w] + AGE_W'(1);
                end else begin
                    r_age[w] <= r_age[w];
                end
            end
        end
    end

    // Oldest way lookup
    always_comb begin
        o_oldest = {AGE_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[w] == AGE_W'(WAYS - 1)) begin
                o_oldest = AGE_W'(w);
            end else begin
                o_oldest = o_oldest;
            end
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with blocking miss FSM.
// Optional macro CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module assoc_cache_ctrl
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int BLOCK_BYTES = 64,
    parameter int SETS        = 128,
    parameter int WAYS        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_hit,
    output logic                     resp_miss,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [BLOCK_BYTES*8-1:0] mem_wdata,
    input  logic                     mem_resp_valid,
    input  logic [BLOCK_BYTES*8-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses,
    output logic [31:0]              stat_writebacks
`endif
);

    localparam int OFFSET_W   = calc_offset_w(BLOCK_BYTES);
    localparam int INDEX_W    = calc_index_w(SETS);
    localparam int TAG_W      = calc_tag_w(ADDR_W, BLOCK_BYTES, SETS);
    localparam int BYTE_W     = calc_byte_w(DATA_W);
    localparam int WORD_SEL_W = calc_word_sel_w(BLOCK_BYTES, DATA_W);
    localparam int LINE_W     = calc_line_w(BLOCK_BYTES);
    localparam int WAY_W      = $clog2(WAYS);
    localparam int WSEL_W     = (WORD_SEL_W > 0) ? WORD_SEL_W : 1;

    cache_state_e r_state;
    cache_state_e w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic [WAY_W-1:0]  r_victim_way;
    logic [LINE_W-1:0] r_victim_line;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_req_ready;

    logic              r_resp_valid;
    logic              r_resp_hit;
    logic              r_resp_miss;
    logic [DATA_W-1:0] r_resp_rdata;

    logic [WAYS-1:0]   r_valid    [SETS];
    logic [WAYS-1:0]   r_dirty    [SETS];
    logic [TAG_W-1:0]  r_tag_arr  [SETS][WAYS];
    logic [LINE_W-1:0] r_data_arr [SETS][WAYS];

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [WSEL_W-1:0]  w_word_sel;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_has_inv;
    logic [WAY_W-1:0]   w_inv_way;
    logic [WAY_W-1:0]   w_victim_way;
    logic               w_victim_dirty;
    logic [WAY_W-1:0]   w_oldest [SETS];
    logic [LINE_W-1:0]  w_base_line;
    logic [LINE_W-1:0]  w_upd_line;
    logic [DATA_W-1:0]  w_sel_word;
    logic               w_accept;
    logic               w_lookup_hit;
    logic               w_lookup_miss;
    logic               w_fill_done;
    logic               w_wb_hs;
    logic               w_resp_set;
    logic               w_arr_we;
    logic [WAY_W-1:0]   w_arr_way;
    logic               w_mem_req_valid;
    logic               w_mem_req_write;

    assign w_index    = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word_sel = WSEL_W'(r_addr[OFFSET_W-1:0] >> BYTE_W);

    assign w_accept      = req_valid && r_req_ready;
    assign w_lookup_hit  = (r_state == ST_LOOKUP) && w_hit;
    assign w_lookup_miss = (r_state == ST_LOOKUP) && !w_hit;
    assign w_fill_done   = (r_state == ST_FILL_WAIT) && mem_resp_valid;
    assign w_wb_hs       = (r_state == ST_WRITEBACK) && mem_req_ready;
    assign w_resp_set    = w_lookup_hit || w_fill_done;
    assign w_arr_we      = (w_lookup_hit && r_write) || w_fill_done;
    assign w_arr_way     = w_fill_done ? r_victim_way : w_hit_way;

    // Tag compare across the ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag_arr[w_index][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end else begin
                w_hit     = w_hit;
                w_hit_way = w_hit_way;
            end
        end
    end

    // Victim choice: lowest-index invalid way first, else the oldest way
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_index][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end else begin
                w_has_inv = w_has_inv;
                w_inv_way = w_inv_way;
            end
        end
        w_victim_way   = w_has_inv ? w_inv_way : w_oldest[w_index];
        w_victim_dirty = r_valid[w_index][w_victim_way] && r_dirty[w_index][w_victim_way];
    end

    // Line seen by the current access and its store-merged version
    always_comb begin
        w_base_line = (r_state == ST_FILL_WAIT) ? mem_rdata : r_data_arr[w_index][w_hit_way];
        w_sel_word  = w_base_line[w_word_sel*DATA_W +: DATA_W];
        w_upd_line  = w_base_line;
        if (r_write) begin
            w_upd_line[w_word_sel*DATA_W +: DATA_W] = r_wdata;
        end else begin
            w_upd_line = w_base_line;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      w_next_state = w_accept ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_next_state = ST_IDLE;
                end else if (w_victim_dirty) begin
                    w_next_state = ST_WRITEBACK;
                end else begin
                    w_next_state = ST_FILL_REQ;
                end
            end
            ST_WRITEBACK: w_next_state = mem_req_ready ? ST_FILL_REQ : ST_WRITEBACK;
            ST_FILL_REQ:  w_next_state = mem_req_ready ? ST_FILL_WAIT : ST_FILL_REQ;
            ST_FILL_WAIT: w_next_state = mem_resp_valid ? ST_IDLE : ST_FILL_WAIT;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // FSM memory-side outputs
    always_comb begin
        w_mem_req_valid = 1'b0;
        w_mem_req_write = 1'b0;
        case (r_state)
            ST_WRITEBACK: begin
                w_mem_req_valid = 1'b1;
                w_mem_req_write = 1'b1;
            end
            ST_FILL_REQ: begin
                w_mem_req_valid = 1'b1;
                w_mem_req_write = 1'b0;
            end
            default: begin
                w_mem_req_valid = 1'b0;
                w_mem_req_write = 1'b0;
            end
        endcase
    end

    assign mem_req_valid = w_mem_req_valid;
    assign mem_req_write = w_mem_req_write;
    assign mem_req_addr  = w_mem_req_valid ? r_mem_addr : {ADDR_W{1'b0}};
    assign mem_wdata     = w_mem_req_write ? r_victim_line : {LINE_W{1'b0}};

    // Request capture and miss context; victim snapshot keeps writeback data stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr        <= {ADDR_W{1'b0}};
            r_wdata       <= {DATA_W{1'b0}};
            r_write       <= 1'b0;
            r_victim_way  <= {WAY_W{1'b0}};
            r_victim_line <= {LINE_W{1'b0}};
            r_mem_addr    <= {ADDR_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_write <= req_write;
            end
            if (w_lookup_miss) begin
                r_victim_way  <= w_victim_way;
                r_victim_line <= r_data_arr[w_index][w_victim_way];
                r_mem_addr    <= w_victim_dirty
                               ? {r_tag_arr[w_index][w_victim_way], w_index, {OFFSET_W{1'b0}}}
                               : {w_tag, w_index, {OFFSET_W{1'b0}}};
            end
            if (w_wb_hs) begin
                r_mem_addr <= {w_tag, w_index, {OFFSET_W{1'b0}}};
            end
        end
    end

    // CPU response pulse and ready; ready stays low for the response cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_miss  <= 1'b0;
            r_resp_rdata <= {DATA_W{1'b0}};
        end else begin
            r_req_ready  <= (w_next_state == ST_IDLE) && !w_resp_set;
            r_resp_valid <= w_resp_set;
            r_resp_hit   <= w_lookup_hit;
            r_resp_miss  <= w_fill_done;
            r_resp_rdata <= (w_resp_set && !r_write) ? w_sel_word : {DATA_W{1'b0}};
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_miss  = r_resp_miss;
    assign resp_rdata = r_resp_rdata;

    // Valid and dirty bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= {WAYS{1'b0}};
                r_dirty[s] <= {WAYS{1'b0}};
            end
        end else if (w_fill_done) begin
            r_valid[w_index][r_victim_way] <= 1'b1;
            r_dirty[w_index][r_victim_way] <= r_write;
        end else if (w_lookup_hit && r_write) begin
            r_dirty[w_index][w_hit_way] <= 1'b1;
        end
    end

    // Tag and data storage; contents survive reset but are never written during it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_arr_we) begin
                r_data_arr[w_index][w_arr_way] <= w_upd_line;
            end
            if (w_fill_done) begin
                r_tag_arr[w_index][r_victim_way] <= w_tag;
            end
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        lru_age_set #(
            .WAYS (WAYS)
        ) u_lru (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_touch  (w_resp_set && (w_index == INDEX_W'(s))),
            .i_way    (w_arr_way),
            .o_oldest (w_oldest[s])
        );
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;
    logic [31:0] r_stat_writebacks;

    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_hits       <= 32'd0;
            r_stat_misses     <= 32'd0;
            r_stat_writebacks <= 32'd0;
        end else begin
            if (w_lookup_hit) begin
                r_stat_hits <= sat_inc32(r_stat_hits);
            end
            if (w_fill_done) begin
                r_stat_misses <= sat_inc32(r_stat_misses);
            end
            if (w_wb_hs) begin
                r_stat_writebacks <= sat_inc32(r_stat_writebacks);
            end
        end
    end

    assign stat_hits       = r_stat_hits;
    assign stat_misses     = r_stat_misses;
    assign stat_writebacks = r_stat_writebacks;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench: acts as CPU and RAM, predicts behaviour from a line-level LRU cache model.
module tb_assoc_cache_ctrl;

    typedef logic [511:0] line_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [63:0]  req_wdata;
    logic         resp_valid;
    logic [63:0]  resp_rdata;
    logic         resp_hit;
    logic         resp_miss;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    line_t        mem_wdata;
    logic         mem_resp_valid;
    line_t        mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
    logic [31:0]  stat_writebacks;
`endif

    always #5 clk = ~clk;

    assoc_cache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_hit       (resp_hit),
        .resp_miss      (resp_miss),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writebacks (stat_writebacks)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: RAM image, cached lines keyed by line address, one global MRU-first recency list
    line_t       ram   [logic [31:0]];
    line_t       mline [logic [31:0]];
    bit          mdirty[logic [31:0]];
    logic [31:0] mru_q [$];
    int          n_hits, n_misses, n_wbs;

    logic [31:0] last_fill_addr;
    logic [31:0] last_wb_addr;
    line_t       last_wb_data;
    logic [63:0] last_rdata;
    bit          last_hit;

    task automatic chk(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic line_t ram_line(input logic [31:0] la);
        line_t l;
        if (ram.exists(la)) return ram[la];
        for (int w = 0; w < 8; w++) l[w*64 +: 64] = {la ^ 32'hA5A5_0000, 32'(w) ^ 32'h1234_5678};
        return l;
    endfunction

    function automatic int set_count(input logic [31:0] la);
        int c = 0;
        foreach (mru_q[i]) if (mru_q[i][12:6] == la[12:6]) c++;
        return c;
    endfunction

    function automatic logic [31:0] lru_of_set(input logic [31:0] la);
        logic [31:0] v = 32'd0;
        foreach (mru_q[i]) if (mru_q[i][12:6] == la[12:6]) v = mru_q[i];
        return v;
    endfunction

    task automatic q_remove(input logic [31:0] la);
        for (int i = 0; i < mru_q.size(); i++) begin
            if (mru_q[i] == la) begin
                mru_q.delete(i);
                break;
            end
        end
    endtask

    task automatic model_reset();
        mline.delete();
        mdirty.delete();
        mru_q.delete();
        n_hits = 0;
        n_misses = 0;
        n_wbs = 0;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                          input int rdy_dly, input int resp_dly, input bit abort);
        logic [31:0] ln, victim;
        int          wsel, n, wait_ct, dly_ct;
        bit          hit, evict, exp_wb, wb_done, freq_done, got_resp;
        line_t       fl, base, newl;
        logic [63:0] exp_rd;

        ln     = {addr[31:6], 6'd0};
        wsel   = int'(addr[5:3]);
        hit    = mline.exists(ln);
        evict  = !hit && (set_count(ln) == 4);
        victim = evict ? lru_of_set(ln) : 32'd0;
        exp_wb = evict && mdirty[victim];
        fl     = ram_line(ln);
        base   = hit ? mline[ln] : fl;
        exp_rd = wr ? 64'd0 : base[wsel*64 +: 64];
        newl   = base;
        if (wr) newl[wsel*64 +: 64] = wd;

        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", line_t'(req_ready), line_t'(1'b1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom};
        chk("req_ready_busy", line_t'(req_ready), line_t'(1'b0));

        wait_ct = 0;
        dly_ct = 0;
        wb_done = 1'b0;
        freq_done = 1'b0;
        got_resp = 1'b0;
        for (n = 1; n < 200 && !got_resp; n++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (resp_valid) begin
                got_resp = 1'b1;
                chk("resp_hit", line_t'(resp_hit), line_t'(hit));
                chk("resp_miss", line_t'(resp_miss), line_t'(!hit));
                chk("resp_rdata", line_t'(resp_rdata), line_t'(exp_rd));
                chk("ready_in_resp", line_t'(req_ready), line_t'(1'b0));
                if (hit) chk("hit_latency", line_t'(n), line_t'(2));
                else chk("miss_sequence", line_t'(freq_done && (wb_done == exp_wb)), line_t'(1'b1));
                last_rdata = resp_rdata;
                last_hit   = resp_hit;
                if (hit) n_hits++; else n_misses++;
                if (exp_wb) begin
                    n_wbs++;
                    ram[victim] = mline[victim];
                end
                if (evict) begin
                    mline.delete(victim);
                    mdirty.delete(victim);
                    q_remove(victim);
                end
                mdirty[ln] = hit ? (mdirty[ln] | wr) : wr;
                mline[ln]  = newl;
                q_remove(ln);
                mru_q.push_front(ln);
`ifdef CACHE_STATS_EN
                chk("stat_hits", line_t'(stat_hits), line_t'(n_hits));
                chk("stat_misses", line_t'(stat_misses), line_t'(n_misses));
                chk("stat_wbs", line_t'(stat_writebacks), line_t'(n_wbs));
`endif
            end else if (mem_req_valid) begin
                chk("ready_in_mem", line_t'(req_ready), line_t'(1'b0));
                if (hit) begin
                    chk("hit_no_mem", line_t'(mem_req_valid), line_t'(1'b0));
                end else if (exp_wb && !wb_done) begin
                    chk("wb_write", line_t'(mem_req_write), line_t'(1'b1));
                    chk("wb_addr", line_t'(mem_req_addr), line_t'(victim));
                    chk("wb_data", mem_wdata, mline[victim]);
                    if (wait_ct >= rdy_dly) begin
                        mem_req_ready = 1'b1;
                        wb_done = 1'b1;
                        last_wb_addr = mem_req_addr;
                        last_wb_data = mem_wdata;
                        wait_ct = 0;
                    end else wait_ct++;
                end else if (!freq_done) begin
                    chk("fill_write", line_t'(mem_req_write), line_t'(1'b0));
                    chk("fill_addr", line_t'(mem_req_addr), line_t'(ln));
                    if (wait_ct >= rdy_dly) begin
                        mem_req_ready = 1'b1;
                        freq_done = 1'b1;
                        last_fill_addr = mem_req_addr;
                    end else wait_ct++;
                end else begin
                    chk("extra_mem_req", line_t'(mem_req_valid), line_t'(1'b0));
                end
            end else if (freq_done) begin
                if (abort) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    chk("abort_mem_valid", line_t'(mem_req_valid), line_t'(1'b0));
                    chk("abort_ready", line_t'(req_ready), line_t'(1'b1));
                    chk("abort_resp", line_t'(resp_valid), line_t'(1'b0));
                    model_reset();
                    return;
                end
                if (dly_ct >= resp_dly) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = fl;
                end else dly_ct++;
            end
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (!got_resp) chk("resp_timeout", line_t'(got_resp), line_t'(1'b1));
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'd0;
        req_wdata = 64'd0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_req_ready", line_t'(req_ready), line_t'(1'b1));
        chk("rst_resp_valid", line_t'(resp_valid), line_t'(1'b0));
        chk("rst_resp_rdata", line_t'(resp_rdata), line_t'(64'd0));
        chk("rst_hit_miss", line_t'({resp_hit, resp_miss}), line_t'(2'b00));
        chk("rst_mem_valid", line_t'({mem_req_valid, mem_req_write}), line_t'(2'b00));
        chk("rst_mem_addr", line_t'(mem_req_addr), line_t'(32'd0));
        chk("rst_mem_wdata", mem_wdata, line_t'(0));

        do_req(1'b0, 32'h0000_0040, 64'd0, 0, 1, 1'b0);
        chk("pin_fill_addr", line_t'(last_fill_addr), line_t'(32'h0000_0040));
        chk("pin_fill_word0", line_t'(last_rdata), line_t'(64'hA5A5_0040_1234_5678));
        do_req(1'b0, 32'h0000_0040, 64'd0, 0, 0, 1'b0);
        chk("pin_repeat_hit", line_t'(last_hit), line_t'(1'b1));
        do_req(1'b1, 32'h0000_0048, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
        do_req(1'b0, 32'h0000_0048, 64'd0, 0, 0, 1'b0);
        chk("pin_store_load", line_t'(last_rdata), line_t'(64'hDEAD_BEEF_CAFE_F00D));

        do_req(1'b0, 32'h0000_0040, 64'd0, 0, 0, 1'b0);
        do_req(1'b0, 32'h0000_2040, 64'd0, 1, 2, 1'b0);
        do_req(1'b0, 32'h0000_4040, 64'd0, 0, 0, 1'b0);
        do_req(1'b0, 32'h0000_6040, 64'd0, 2, 0, 1'b0);
        do_req(1'b0, 32'h0000_8040, 64'd0, 5, 1, 1'b0);
        chk("pin_wb_addr", line_t'(last_wb_addr), line_t'(32'h0000_0040));
        chk("pin_wb_word1", line_t'(last_wb_data[127:64]), line_t'(64'hDEAD_BEEF_CAFE_F00D));
        do_req(1'b0, 32'h0000_0048, 64'd0, 0, 0, 1'b0);
        chk("pin_refetch_miss", line_t'(last_hit), line_t'(1'b0));
        chk("pin_refetch_data", line_t'(last_rdata), line_t'(64'hDEAD_BEEF_CAFE_F00D));
`ifdef CACHE_STATS_EN
        chk("pin_stat_hits", line_t'(stat_hits), line_t'(32'd4));
        chk("pin_stat_misses", line_t'(stat_misses), line_t'(32'd6));
        chk("pin_stat_wbs", line_t'(stat_writebacks), line_t'(32'd1));
`endif

        do_req(1'b0, 32'h0001_0080, 64'd0, 0, 3, 1'b1);
        do_req(1'b0, 32'h0001_0080, 64'd0, 0, 0, 1'b0);
        chk("pin_after_abort_miss", line_t'(last_hit), line_t'(1'b0));

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata = {16{$urandom}};
                @(negedge clk);
                mem_resp_valid = 1'b0;
            end
            a = {16'd0, 3'(4'($urandom_range(0, 5))), 7'($urandom_range(0, 2)), 6'($urandom)};
            do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
